// File: rtl/integrator.sv
`default_nettype none
// ============================================================================
// Module      : integrator
// Description : Discrete-time accumulating integrator for a signed sample
//               stream. Every rising clock edge adds In to a wide saturating
//               accumulator; Out is the accumulator arithmetically shifted
//               right by GAIN_SHIFT, clamped to DATA_W bits and registered.
// Ports       : clk   - system clock, all state updates on rising edge
//               reset - asynchronous active-low reset (0 clears acc and Out)
//               In    - signed input sample, consumed every clock
//               Out   - signed registered, scaled, saturated integral
// Revision    : 1.0 - initial release
// ============================================================================
module integrator #(
  parameter int DATA_W     = 22,
  parameter int ACC_W      = 32,  // must be >= DATA_W + GAIN_SHIFT + 1
  parameter int GAIN_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] In,
  output logic signed [DATA_W-1:0] Out
);

  localparam logic signed [ACC_W-1:0]  c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] c_OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] c_OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [DATA_W-1:0] out_d;

  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic [ACC_W-DATA_W:0]    w_hi;

  // One guard bit is enough: the sum of two ACC_W-bit signed values always
  // fits in ACC_W+1 bits, and the top two bits disagree exactly on overflow.
  assign w_sum = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W+1-DATA_W){In[DATA_W-1]}}, In};

  always_comb begin
    acc_d = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      acc_d = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    end
  end

  // Output is derived from the freshly updated accumulator so that the
  // sample at edge k appears in Out right after edge k.
  assign w_shift = acc_d >>> GAIN_SHIFT;

  // The shifted value fits DATA_W bits only if every bit from the output
  // sign position upward is a copy of the sign.
  assign w_hi = w_shift[ACC_W-1:DATA_W-1];

  always_comb begin
    out_d = w_shift[DATA_W-1:0];
    if (!((&w_hi) || !(|w_hi))) begin
      out_d = w_shift[ACC_W-1] ? c_OUT_MIN : c_OUT_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      Out   <= '0;
    end else begin
      acc_q <= acc_d;
      Out   <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_integrator
// Description : Self-checking bench for integrator. Two instances share the
//               stimulus: one with default gain, one with GAIN_SHIFT = 2.
//               Directed vector table, hand-written multi-cycle sequences,
//               and randomized stimulus against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integrator;

  localparam int DW = 22;

  logic                 clk;
  logic                 reset;
  logic signed [DW-1:0] in_s;
  logic signed [DW-1:0] out0;
  logic signed [DW-1:0] out2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: plain integers, clamped with ordinary arithmetic.
  longint m_acc0 = 0;
  longint m_acc2 = 0;

  integrator #(.DATA_W(DW), .ACC_W(32), .GAIN_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .In(in_s), .Out(out0)
  );

  integrator #(.DATA_W(DW), .ACC_W(32), .GAIN_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .In(in_s), .Out(out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                 rst_n;
    logic signed [DW-1:0] din;
    logic signed [DW-1:0] exp;
  } vec_t;

  function automatic longint clamp(input longint v, input int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint m_out0();
    return clamp(m_acc0, DW);
  endfunction

  function automatic longint m_out2();
    return clamp(m_acc2 >>> 2, DW);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc0 = 0;
    m_acc2 = 0;
  endtask

  // Drive one sample at the falling edge, take the rising edge, sample #1 after.
  task automatic step(input logic rst_n, input logic signed [DW-1:0] d);
    @(negedge clk);
    reset = rst_n;
    in_s  = d;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      m_acc0 = clamp(m_acc0 + longint'(d), 32);
      m_acc2 = clamp(m_acc2 + longint'(d), 32);
    end
    #1;
  endtask

  task automatic check_models(input string tag);
    check({tag, "_g0"}, out0, m_out0());
    check({tag, "_g2"}, out2, m_out2());
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b0;
    in_s  = '0;
    #1;
    check("reset_state_g0", out0, 0);
    check("reset_state_g2", out2, 0);

    // Directed table: reset hold, ramp, signed mix, positive saturation.
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 22'sd5, 22'sd0});
    vecs.push_back('{1'b1, 22'sd5, 22'sd5});
    vecs.push_back('{1'b0, 22'sd0, 22'sd0});
    for (int i = 1; i <= 10; i++) vecs.push_back('{1'b1, 22'sd1, DW'(i)});
    vecs.push_back('{1'b0, 22'sd0, 22'sd0});
    vecs.push_back('{1'b1, 22'sd100,  22'sd100});
    vecs.push_back('{1'b1, -22'sd30,  22'sd70});
    vecs.push_back('{1'b1, -22'sd100, -22'sd30});
    vecs.push_back('{1'b1, 22'sd0,    -22'sd30});
    vecs.push_back('{1'b0, 22'sd0, 22'sd0});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 22'h1FFFFF, 22'h1FFFFF});
    vecs.push_back('{1'b1, -22'sh100000, 22'h1FFFFF});

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].din);
      check($sformatf("vec%0d", i), out0, vecs[i].exp);
      check_models($sformatf("vec%0d_model", i));
    end
    // Accumulator must be 3*0x1FFFFF - 0x100000 internally, still above rail.
    check("pos_sat_acc", longint'(dut0.acc_q), 64'sd5242877);

    // Negative saturation with gain 2^-2.
    step(1'b0, '0);
    begin
      longint exp2 [4] = '{-2, -4, -6, -8};
      for (int i = 0; i < 4; i++) begin
        step(1'b1, -22'sd8);
        check($sformatf("g2_ramp%0d", i), out2, exp2[i]);
      end
    end
    for (int i = 0; i < 1100; i++) begin
      step(1'b1, 22'sh200000);
      if (out2 != -22'sh200000 && i > 2) begin
        check($sformatf("g2_negsat%0d", i), out2, -2097152);
      end
    end
    check("g2_negsat_final", out2, -2097152);
    check("g0_negsat_final", out0, -2097152);
    check_models("negsat");

    // Asynchronous mid-run reset between edges.
    step(1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 22'sd10);
    check("mid_pre50", out0, 50);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("mid_async_g0", out0, 0);
    check("mid_async_g2", out2, 0);
    step(1'b1, 22'sd7);
    check("mid_after7", out0, 7);
    check_models("mid_after");

    // Randomized stimulus against the arithmetic reference.
    for (int i = 0; i < 400; i++) begin
      logic signed [DW-1:0] d;
      logic                 r;
      case ($urandom_range(0, 4))
        0: d = DW'(int'($urandom_range(0, 400)) - 200);
        1: d = 22'h1FFFFF;
        2: d = 22'sh200000;
        default: d = DW'($urandom);
      endcase
      r = ($urandom_range(0, 60) != 0);
      step(r, d);
      check_models($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
